// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network sequencer.
// Holds the controller state encoding and the width helpers that size
// thresholds and the serial parameter stream.
package bnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HIDDEN = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Threshold width able to hold a popcount of n inputs (0..n).
  function automatic int th_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int th_i(input int in_w);
    return th_w(in_w);
  endfunction

  function automatic int th_h(input int hid);
    return th_w(hid);
  endfunction

  // Total serial parameter stream length in bits.
  function automatic int p_len(input int in_w, input int hid, input int out_w);
    return hid * (in_w + th_i(in_w)) + out_w * (hid + th_h(hid));
  endfunction

endpackage

// File: rtl/bnn_seq_engine_if.sv
// Handshake bundle for bnn_seq_engine: parameter load, input vector, result.
// master = environment side (drives requests), slave = engine side.
// Ports: load_start/param_valid/param_bit/load_done, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, busy.
interface bnn_seq_engine_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
);
  logic             load_start;
  logic             param_valid;
  logic             param_bit;
  logic             load_done;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             busy;

  modport master (
    output load_start, param_valid, param_bit, in_valid, in_data, out_ready,
    input  load_done, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  load_start, param_valid, param_bit, in_valid, in_data, out_ready,
    output load_done, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/bnn_neuron_eval.sv
// Purpose: binary neuron, fires when popcount(XNOR(weights, x)) >= threshold.
// Latency: purely combinational, no state.
// Backpressure: none; ports weights_i/x_i (INPUTS bits), th_i, fire_o.
module bnn_neuron_eval #(
  parameter  int INPUTS = 8,
  localparam int TH_W   = $clog2(INPUTS + 1)
) (
  input  logic [INPUTS-1:0] weights_i,
  input  logic [INPUTS-1:0] x_i,
  input  logic [TH_W-1:0]   th_i,
  output logic              fire_o
);

  logic [TH_W-1:0] match_cnt;

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < INPUTS; i++) begin
      match_cnt = match_cnt + TH_W'(weights_i[i] ~^ x_i[i]);
    end
    fire_o = (match_cnt >= th_i);
  end

endmodule

// File: rtl/bnn_seq_engine.sv
// Purpose: two-layer binary NN; serial parameter load, one neuron per cycle.
// Latency: input accept to out_valid = HID + OUT_W cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (bnn_seq_engine_if.slave).
module bnn_seq_engine
  import bnn_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int HID   = 8,
  parameter int OUT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bnn_seq_engine_if.slave bus
);

  localparam int TH_I     = th_i(IN_W);
  localparam int TH_H     = th_h(HID);
  localparam int P        = p_len(IN_W, HID, OUT_W);
  localparam int HID_BASE = HID * (IN_W + TH_I);
  localparam int CNT_W    = $clog2(P + 1);
  localparam int MAXN     = (HID > OUT_W) ? HID : OUT_W;
  localparam int IDX_W    = $clog2(MAXN + 1);

  state_e           state_q, state_d;
  logic [P-1:0]     params_q, params_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [HID-1:0]   hid_q, hid_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             load_done_q, load_done_d;

  logic accept, cap, last_bit, last_hid, last_out;

  // load_start has priority over an input offered in the same IDLE cycle.
  assign accept   = (state_q == ST_IDLE) && bus.in_valid && !bus.load_start;
  assign cap      = (state_q == ST_LOAD) && bus.param_valid;
  assign last_bit = cap && (cnt_q == CNT_W'(P - 1));
  assign last_hid = (idx_q == IDX_W'(HID - 1));
  assign last_out = (idx_q == IDX_W'(OUT_W - 1));

  // Parameter fields for the neuron currently being evaluated.
  logic [CNT_W-1:0] h_off, o_off;
  logic [IN_W-1:0]  hid_w;
  logic [TH_I-1:0]  hid_th;
  logic [HID-1:0]   out_w;
  logic [TH_H-1:0]  out_th;
  logic             hid_fire, out_fire;

  always_comb begin
    h_off  = CNT_W'(idx_q) * CNT_W'(IN_W + TH_I);
    o_off  = CNT_W'(HID_BASE) + CNT_W'(idx_q) * CNT_W'(HID + TH_H);
    hid_w  = IN_W'(params_q >> h_off);
    hid_th = TH_I'(params_q >> (h_off + CNT_W'(IN_W)));
    out_w  = HID'(params_q >> o_off);
    out_th = TH_H'(params_q >> (o_off + CNT_W'(HID)));
  end

  // One evaluator per layer, time-multiplexed across that layer's neurons.
  bnn_neuron_eval #(.INPUTS(IN_W)) u_hid_eval (
    .weights_i (hid_w),
    .x_i       (x_q),
    .th_i      (hid_th),
    .fire_o    (hid_fire)
  );

  bnn_neuron_eval #(.INPUTS(HID)) u_out_eval (
    .weights_i (out_w),
    .x_i       (hid_q),
    .th_i      (out_th),
    .fire_o    (out_fire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start)  state_d = ST_LOAD;
        else if (accept)     state_d = ST_HIDDEN;
      end
      ST_LOAD:   if (last_bit)      state_d = ST_IDLE;
      ST_HIDDEN: if (last_hid)      state_d = ST_OUTPUT;
      ST_OUTPUT: if (last_out)      state_d = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
    bus.load_done = load_done_q;
    bus.out_data  = out_q;
  end

  // Datapath next-state.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    params_d    = params_q;
    x_d         = x_q;
    hid_d       = hid_q;
    acc_d       = acc_q;
    out_d       = out_q;
    load_done_d = last_bit;

    if ((state_q == ST_IDLE) && bus.load_start) cnt_d = '0;
    if (cap) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int i = 0; i < P; i++) begin
        if (cnt_q == CNT_W'(i)) params_d[i] = bus.param_bit;
      end
    end

    if (accept) begin
      x_d   = bus.in_data;
      idx_d = '0;
    end

    if (state_q == ST_HIDDEN) begin
      for (int i = 0; i < HID; i++) begin
        if (idx_q == IDX_W'(i)) hid_d[i] = hid_fire;
      end
      idx_d = last_hid ? '0 : idx_q + IDX_W'(1);
    end

    if (state_q == ST_OUTPUT) begin
      for (int i = 0; i < OUT_W; i++) begin
        if (idx_q == IDX_W'(i)) acc_d[i] = out_fire;
      end
      idx_d = idx_q + IDX_W'(1);
      // out_data only changes once a complete result exists.
      if (last_out) out_d = acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      params_q    <= '0;
      x_q         <= '0;
      hid_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      load_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      params_q    <= params_d;
      x_q         <= x_d;
      hid_q       <= hid_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      load_done_q <= load_done_d;
    end
  end

endmodule

// File: tb/tb_bnn_seq_engine.sv
// Bench for bnn_seq_engine (IN_W=HID=OUT_W=8, parameter stream of 192 bits).
// Stimulus pushes expected results into a queue; a negedge monitor pops them.
// Parameter sets: A = all weights FF, threshold 8; B = weights FF, threshold n+1.
module tb_bnn_seq_engine;

  localparam int P = 192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_seq_engine_if #(.IN_W(8), .OUT_W(8)) bus();

  bnn_seq_engine #(.IN_W(8), .HID(8), .OUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] dat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h want none", bus.out_data);
          end else begin
            if (!prev_v) chk("latency", 32'(cyc - exp_q[0].acc), 32'd16);
            chk("out_data", {24'd0, bus.out_data}, {24'd0, exp_q[0].dat});
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        prev_v = bus.out_valid && !bus.out_ready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [P-1:0] mk_stream(input bit thermo);
    logic [P-1:0] s;
    logic [3:0]   th;
    s = '0;
    for (int n = 0; n < 8; n++) begin
      th = thermo ? 4'(n + 1) : 4'd8;
      s[n*12 +: 8]        = 8'hFF;
      s[n*12 + 8 +: 4]    = th;
      s[96 + n*12 +: 8]   = 8'hFF;
      s[96 + n*12 + 8 +: 4] = th;
    end
    return s;
  endfunction

  task automatic send(input logic [7:0] v, input logic [7:0] e, input bit push);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) exp_q.push_back('{e, cyc});
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic load_stream(input logic [P-1:0] s, input bit gap, input bit hold_iv,
                             input bit skip_start);
    bit rdy_seen, early;
    rdy_seen = 1'b0;
    early    = 1'b0;
    if (!skip_start) begin
      @(posedge clk); #1;
      bus.load_start = 1'b1;
      bus.in_valid   = hold_iv;
      bus.in_data    = 8'h5A;
    end
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    for (int i = 0; i < P; i++) begin
      bus.param_valid = 1'b1;
      bus.param_bit   = s[i];
      @(negedge clk);
      if (bus.in_ready) rdy_seen = 1'b1;
      if (bus.load_done) early = 1'b1;
      @(posedge clk); #1;
      if (gap && i != P - 1) begin
        bus.param_valid = 1'b0;
        bus.param_bit   = ~s[i];
        @(negedge clk);
        if (bus.in_ready) rdy_seen = 1'b1;
        if (bus.load_done) early = 1'b1;
        @(posedge clk); #1;
      end
    end
    bus.param_valid = 1'b0;
    bus.in_valid    = 1'b0;
    @(negedge clk);
    chk("ld_done",  {31'd0, bus.load_done}, 32'd1);
    chk("ld_busy",  {31'd0, bus.busy}, 32'd0);
    chk("ld_rdy0",  {31'd0, rdy_seen}, 32'd0);
    chk("ld_early", {31'd0, early}, 32'd0);
    @(negedge clk);
    chk("ld_pulse", {31'd0, bus.load_done}, 32'd0);
  endtask

  initial begin
    int n;
    bus.load_start  = 1'b0;
    bus.param_valid = 1'b0;
    bus.param_bit   = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.out_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);

    // Zero parameters: every threshold is 0 so everything fires.
    send(8'h00, 8'hFF, 1'b1);
    drain();

    // Slow load of set A with an input offered throughout.
    load_stream(mk_stream(1'b0), 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'hFE, 8'h00, 1'b1);
    send(8'h00, 8'h00, 1'b1);
    drain();

    // load_start and in_valid together: load wins, input ignored.
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'h3C;
    @(negedge clk);
    chk("coll_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    @(negedge clk);
    chk("coll_busy", {31'd0, bus.busy}, 32'd1);
    chk("coll_rdy",  {31'd0, bus.in_ready}, 32'd0);
    load_stream(mk_stream(1'b1), 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);

    // Set B gives a thermometer of popcount(in).
    send(8'h07, 8'h07, 1'b1);
    send(8'hA5, 8'h0F, 1'b1);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'h00, 8'h00, 1'b1);
    drain();

    // Result held while out_ready is low.
    bus.out_ready = 1'b0;
    send(8'h03, 8'h03, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("hold_reach_done", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data",  {24'd0, bus.out_data}, 32'h03);
      chk("hold_rdy",   {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    send(8'hF0, 8'h0F, 1'b1);
    drain();

    // Reset in the middle of the hidden layer (index 3).
    send(8'h55, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_out_data",  {24'd0, bus.out_data}, 32'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("mid_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    send(8'h00, 8'hFF, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
